// File: rtl/id_ex_stage_if.sv
// ID -> EX bus: decoded control word, operands and specifiers entering the
// stage, and their registered copies leaving it.
interface id_ex_stage_if #(
  parameter int unsigned DATA_W = 32
);
  logic              id_valid;
  logic              id_reg_dst;
  logic              id_jump;
  logic              id_branch;
  logic              id_mem_to_reg;
  logic              id_alu_src;
  logic              id_reg_write;
  logic [1:0]        id_mem_read;
  logic [1:0]        id_mem_write;
  logic [3:0]        id_alu_op;
  logic [DATA_W-1:0] id_pc_plus4;
  logic [DATA_W-1:0] id_rd1;
  logic [DATA_W-1:0] id_rd2;
  logic [DATA_W-1:0] id_imm;
  logic [4:0]        id_rs;
  logic [4:0]        id_rt;
  logic [4:0]        id_rd;
  logic              id_uses_rt;

  logic              ex_valid;
  logic              ex_reg_dst;
  logic              ex_jump;
  logic              ex_branch;
  logic              ex_mem_to_reg;
  logic              ex_alu_src;
  logic              ex_reg_write;
  logic [1:0]        ex_mem_read;
  logic [1:0]        ex_mem_write;
  logic [3:0]        ex_alu_op;
  logic [DATA_W-1:0] ex_pc_plus4;
  logic [DATA_W-1:0] ex_rd1;
  logic [DATA_W-1:0] ex_rd2;
  logic [DATA_W-1:0] ex_imm;
  logic [4:0]        ex_rs;
  logic [4:0]        ex_rt;
  logic [4:0]        ex_rd;
  logic [4:0]        ex_dest;

  // Decode side: drives the ID fields, observes the EX copies.
  modport master (
    output id_valid, id_reg_dst, id_jump, id_branch, id_mem_to_reg, id_alu_src,
           id_reg_write, id_mem_read, id_mem_write, id_alu_op, id_pc_plus4,
           id_rd1, id_rd2, id_imm, id_rs, id_rt, id_rd, id_uses_rt,
    input  ex_valid, ex_reg_dst, ex_jump, ex_branch, ex_mem_to_reg, ex_alu_src,
           ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_op, ex_pc_plus4,
           ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt, ex_rd, ex_dest
  );

  // Pipeline register side.
  modport slave (
    input  id_valid, id_reg_dst, id_jump, id_branch, id_mem_to_reg, id_alu_src,
           id_reg_write, id_mem_read, id_mem_write, id_alu_op, id_pc_plus4,
           id_rd1, id_rd2, id_imm, id_rs, id_rt, id_rd, id_uses_rt,
    output ex_valid, ex_reg_dst, ex_jump, ex_branch, ex_mem_to_reg, ex_alu_src,
           ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_op, ex_pc_plus4,
           ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt, ex_rd, ex_dest
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble injection
// (flush / stall / invalid ID), hold, and a saturating bubble counter.
module id_ex_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  id_ex_stage_if.slave     bus,
  input  logic             flush,
  input  logic             hold,
  output logic             load_use_stall,
  output logic             pc_write,
  output logic             if_id_write,
  output logic [CNT_W-1:0] bubble_count
);

  logic              valid_q, reg_dst_q, jump_q, branch_q, mem_to_reg_q;
  logic              alu_src_q, reg_write_q;
  logic [1:0]        mem_read_q, mem_write_q;
  logic [3:0]        alu_op_q;
  logic [DATA_W-1:0] pc_plus4_q, rd1_q, rd2_q, imm_q;
  logic [4:0]        rs_q, rt_q, rd_q, dest_q;

  logic load_en;
  logic bubble;
  logic count_en;

  // Hazard: a load in EX writing a register the ID instruction reads.
  always_comb begin
    load_use_stall = valid_q & (mem_read_q != 2'b00) & reg_write_q &
                     (dest_q != 5'd0) & bus.id_valid &
                     ((dest_q == bus.id_rs) |
                      (bus.id_uses_rt & (dest_q == bus.id_rt)));
    pc_write    = ~(load_use_stall | hold);
    if_id_write = ~(load_use_stall | hold);
    // flush overrides hold; an invalid ID slot becomes an uncounted bubble.
    load_en  = flush | ~hold;
    bubble   = flush | load_use_stall | ~bus.id_valid;
    count_en = flush | (~hold & load_use_stall);
  end

  // Pipeline register: data/specifiers always load; controls are forced to
  // constants on a bubble so unknown decoder outputs never reach EX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q      <= 1'b0;
      reg_dst_q    <= 1'b0;
      jump_q       <= 1'b0;
      branch_q     <= 1'b0;
      mem_to_reg_q <= 1'b0;
      alu_src_q    <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= '0;
      mem_write_q  <= '0;
      alu_op_q     <= '0;
      pc_plus4_q   <= '0;
      rd1_q        <= '0;
      rd2_q        <= '0;
      imm_q        <= '0;
      rs_q         <= '0;
      rt_q         <= '0;
      rd_q         <= '0;
      dest_q       <= '0;
    end else if (load_en) begin
      pc_plus4_q <= bus.id_pc_plus4;
      rd1_q      <= bus.id_rd1;
      rd2_q      <= bus.id_rd2;
      imm_q      <= bus.id_imm;
      rs_q       <= bus.id_rs;
      rt_q       <= bus.id_rt;
      rd_q       <= bus.id_rd;
      if (bubble) begin
        valid_q      <= 1'b0;
        reg_dst_q    <= 1'b0;
        jump_q       <= 1'b0;
        branch_q     <= 1'b0;
        mem_to_reg_q <= 1'b0;
        alu_src_q    <= 1'b0;
        reg_write_q  <= 1'b0;
        mem_read_q   <= '0;
        mem_write_q  <= '0;
        alu_op_q     <= '0;
        // reg_dst is 0 in a bubble, so the destination tracks rt.
        dest_q       <= bus.id_rt;
      end else begin
        valid_q      <= 1'b1;
        reg_dst_q    <= bus.id_reg_dst;
        jump_q       <= bus.id_jump;
        branch_q     <= bus.id_branch;
        mem_to_reg_q <= bus.id_mem_to_reg;
        alu_src_q    <= bus.id_alu_src;
        reg_write_q  <= bus.id_reg_write;
        mem_read_q   <= bus.id_mem_read;
        mem_write_q  <= bus.id_mem_write;
        alu_op_q     <= bus.id_alu_op;
        dest_q       <= bus.id_reg_dst ? bus.id_rd : bus.id_rt;
      end
    end
  end

  // Saturating count of bubbles injected by flush or load-use stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_count <= '0;
    end else if (count_en && (bubble_count != '1)) begin
      bubble_count <= bubble_count + 1'b1;
    end
  end

  // Drive the EX-side bus from the pipeline registers.
  always_comb begin
    bus.ex_valid      = valid_q;
    bus.ex_reg_dst    = reg_dst_q;
    bus.ex_jump       = jump_q;
    bus.ex_branch     = branch_q;
    bus.ex_mem_to_reg = mem_to_reg_q;
    bus.ex_alu_src    = alu_src_q;
    bus.ex_reg_write  = reg_write_q;
    bus.ex_mem_read   = mem_read_q;
    bus.ex_mem_write  = mem_write_q;
    bus.ex_alu_op     = alu_op_q;
    bus.ex_pc_plus4   = pc_plus4_q;
    bus.ex_rd1        = rd1_q;
    bus.ex_rd2        = rd2_q;
    bus.ex_imm        = imm_q;
    bus.ex_rs         = rs_q;
    bus.ex_rt         = rt_q;
    bus.ex_rd         = rd_q;
    bus.ex_dest       = dest_q;
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, pass-through, load-use stall,
// false-hazard cases, flush/hold interaction and counter saturation.
module tb_id_ex_stage;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 4;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic             hold;
  logic             load_use_stall;
  logic             pc_write;
  logic             if_id_write;
  logic [CNT_W-1:0] bubble_count;

  int checks = 0;
  int errors = 0;

  id_ex_stage_if #(.DATA_W(DATA_W)) bus ();

  id_ex_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .flush          (flush),
    .hold           (hold),
    .load_use_stall (load_use_stall),
    .pc_write       (pc_write),
    .if_id_write    (if_id_write),
    .bubble_count   (bubble_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drive one decoded instruction onto the ID side.
  task automatic drive(input logic v, input logic rdst, input logic [1:0] mr,
                       input logic mtr, input logic asrc, input logic rw,
                       input logic [3:0] aop, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd,
                       input logic urt, input logic [31:0] d1,
                       input logic [31:0] imm);
    bus.id_valid      = v;
    bus.id_reg_dst    = rdst;
    bus.id_jump       = 1'b0;
    bus.id_branch     = 1'b0;
    bus.id_mem_to_reg = mtr;
    bus.id_alu_src    = asrc;
    bus.id_reg_write  = rw;
    bus.id_mem_read   = mr;
    bus.id_mem_write  = 2'b00;
    bus.id_alu_op     = aop;
    bus.id_rs         = rs;
    bus.id_rt         = rt;
    bus.id_rd         = rd;
    bus.id_uses_rt    = urt;
    bus.id_rd1        = d1;
    bus.id_rd2        = d1 + 32'h1;
    bus.id_imm        = imm;
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    hold  = 1'b0;
    // Nonzero inputs everywhere
    bus.id_valid = 1'b1;      bus.id_reg_dst = 1'b1;   bus.id_jump = 1'b1;
    bus.id_branch = 1'b1;     bus.id_mem_to_reg = 1'b1; bus.id_alu_src = 1'b1;
    bus.id_reg_write = 1'b1;  bus.id_mem_read = 2'b11; bus.id_mem_write = 2'b10;
    bus.id_alu_op = 4'hA;     bus.id_pc_plus4 = 32'h100; bus.id_rd1 = 32'h11;
    bus.id_rd2 = 32'h22;      bus.id_imm = 32'h33;     bus.id_rs = 5'd1;
    bus.id_rt = 5'd2;         bus.id_rd = 5'd3;        bus.id_uses_rt = 1'b1;
    #1;
    chk("rst_valid", bus.ex_valid, 1'b0);
    chk("rst_pcw", pc_write, 1'b1);
    chk("rst_ifidw", if_id_write, 1'b1);
    #11 rst_n = 1'b1;
    tick;                                  // edge at 15
    chk("first_valid", bus.ex_valid, 1'b1);
    chk("first_aluop", bus.ex_alu_op, 4'hA);
    chk("first_dest", bus.ex_dest, 5'd3);
    chk("first_jump", bus.ex_jump, 1'b1);
    chk("first_mw", bus.ex_mem_write, 2'b10);
    // Asynchronous reset mid-cycle
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", bus.ex_valid, 1'b0);
    chk("arst_aluop", bus.ex_alu_op, 4'h0);
    chk("arst_rd1", bus.ex_rd1, 32'h0);
    chk("arst_pc", bus.ex_pc_plus4, 32'h0);
    chk("arst_dest", bus.ex_dest, 5'd0);
    chk("arst_cnt", bubble_count, 4'd0);
    chk("arst_pcw", pc_write, 1'b1);
    chk("arst_ifidw", if_id_write, 1'b1);
    #1 rst_n = 1'b1;

    // Pass-through: addi rt=8, then R-type rd=9
    drive(1, 0, 2'b00, 0, 1, 1, 4'b0100, 5'd3, 5'd8, 5'd0, 0, 32'h10, 32'h5);
    bus.id_pc_plus4 = 32'h104;
    tick;
    chk("addi_valid", bus.ex_valid, 1'b1);
    chk("addi_aluop", bus.ex_alu_op, 4'b0100);
    chk("addi_asrc", bus.ex_alu_src, 1'b1);
    chk("addi_rw", bus.ex_reg_write, 1'b1);
    chk("addi_rd1", bus.ex_rd1, 32'h10);
    chk("addi_imm", bus.ex_imm, 32'h5);
    chk("addi_pc", bus.ex_pc_plus4, 32'h104);
    chk("addi_dest", bus.ex_dest, 5'd8);
    drive(1, 1, 2'b00, 0, 0, 1, 4'b0010, 5'd1, 5'd2, 5'd9, 1, 32'hAA, 32'h0);
    tick;
    chk("rtype_dest", bus.ex_dest, 5'd9);
    chk("rtype_rd2", bus.ex_rd2, 32'hAB);
    chk("rtype_rdst", bus.ex_reg_dst, 1'b1);
    chk("rtype_asrc", bus.ex_alu_src, 1'b0);

    // Load-use: lw rt=5 then consumer rs=5
    drive(1, 0, 2'b01, 1, 1, 1, 4'b0000, 5'd2, 5'd5, 5'd0, 0, 32'h0, 32'h4);
    tick;
    chk("lw_mr", bus.ex_mem_read, 2'b01);
    chk("lw_dest", bus.ex_dest, 5'd5);
    drive(1, 1, 2'b00, 0, 0, 1, 4'b0010, 5'd5, 5'd6, 5'd7, 1, 32'h55, 32'h0);
    #1;
    chk("lu_stall", load_use_stall, 1'b1);
    chk("lu_pcw", pc_write, 1'b0);
    chk("lu_ifidw", if_id_write, 1'b0);
    tick;
    chk("lu_bub_valid", bus.ex_valid, 1'b0);
    chk("lu_bub_rw", bus.ex_reg_write, 1'b0);
    chk("lu_bub_mr", bus.ex_mem_read, 2'b00);
    chk("lu_bub_mtr", bus.ex_mem_to_reg, 1'b0);
    chk("lu_bub_asrc", bus.ex_alu_src, 1'b0);
    chk("lu_cnt1", bubble_count, 4'd1);
    chk("lu_stall_off", load_use_stall, 1'b0);
    chk("lu_pcw_back", pc_write, 1'b1);
    tick;
    chk("lu_dep_valid", bus.ex_valid, 1'b1);
    chk("lu_dep_dest", bus.ex_dest, 5'd7);
    chk("lu_dep_rd1", bus.ex_rd1, 32'h55);
    chk("lu_cnt_still1", bubble_count, 4'd1);

    // No false hazard: lw to $0
    drive(1, 0, 2'b01, 1, 1, 1, 4'b0000, 5'd2, 5'd0, 5'd0, 0, 32'h0, 32'h4);
    tick;
    drive(1, 1, 2'b00, 0, 0, 1, 4'b0010, 5'd0, 5'd0, 5'd7, 1, 32'h0, 32'h0);
    #1;
    chk("nohaz_r0", load_use_stall, 1'b0);
    tick;
    drive(1, 0, 2'b01, 1, 1, 1, 4'b0000, 5'd2, 5'd5, 5'd0, 0, 32'h0, 32'h4);
    tick;
    // rt match but rt not a source
    drive(1, 1, 2'b00, 0, 0, 1, 4'b0010, 5'd1, 5'd5, 5'd7, 0, 32'h0, 32'h0);
    #1;
    chk("nohaz_urt0", load_use_stall, 1'b0);
    bus.id_uses_rt = 1'b1;
    #1;
    chk("haz_urt1", load_use_stall, 1'b1);
    // flush together with load-use: one bubble, +1
    flush = 1'b1;
    tick;
    flush = 1'b0;
    chk("fl_lu_valid", bus.ex_valid, 1'b0);
    chk("fl_lu_cnt", bubble_count, 4'd2);

    // Hold for 3 cycles freezes EX
    drive(1, 0, 2'b00, 0, 1, 1, 4'b0100, 5'd3, 5'd8, 5'd0, 0, 32'h77, 32'h9);
    tick;
    chk("pre_hold_rd1", bus.ex_rd1, 32'h77);
    hold = 1'b1;
    drive(1, 1, 2'b00, 0, 0, 1, 4'b0001, 5'd4, 5'd3, 5'd12, 1, 32'h99, 32'h1);
    tick; tick; tick;
    chk("hold_rd1", bus.ex_rd1, 32'h77);
    chk("hold_aluop", bus.ex_alu_op, 4'b0100);
    chk("hold_dest", bus.ex_dest, 5'd8);
    chk("hold_valid", bus.ex_valid, 1'b1);
    chk("hold_pcw", pc_write, 1'b0);
    chk("hold_cnt", bubble_count, 4'd2);
    flush = 1'b1;
    tick;
    chk("fl_hold_valid", bus.ex_valid, 1'b0);
    chk("fl_hold_aluop", bus.ex_alu_op, 4'h0);
    chk("fl_hold_cnt", bubble_count, 4'd3);
    flush = 1'b0;
    hold  = 1'b0;

    // Hold with a pending load-use: frozen, stall re-evaluated afterwards
    drive(1, 0, 2'b01, 1, 1, 1, 4'b0000, 5'd2, 5'd5, 5'd0, 0, 32'h0, 32'h4);
    tick;
    drive(1, 1, 2'b00, 0, 0, 1, 4'b0010, 5'd5, 5'd6, 5'd7, 0, 32'h66, 32'h0);
    hold = 1'b1;
    #1;
    chk("hlu_stall", load_use_stall, 1'b1);
    chk("hlu_pcw", pc_write, 1'b0);
    tick;
    chk("hlu_frozen_mr", bus.ex_mem_read, 2'b01);
    chk("hlu_frozen_valid", bus.ex_valid, 1'b1);
    chk("hlu_cnt", bubble_count, 4'd3);
    hold = 1'b0;
    #1;
    chk("hlu_pcw_stall", pc_write, 1'b0);
    tick;
    chk("hlu_bub_valid", bus.ex_valid, 1'b0);
    chk("hlu_bub_cnt", bubble_count, 4'd4);
    tick;
    chk("hlu_dep_dest", bus.ex_dest, 5'd7);
    chk("hlu_dep_rd1", bus.ex_rd1, 32'h66);

    // Invalid ID with unknown controls: uncounted bubble, no X propagation
    bus.id_valid      = 1'b0;
    bus.id_reg_dst    = 1'bx;
    bus.id_reg_write  = 1'bx;
    bus.id_mem_read   = 2'bxx;
    bus.id_alu_op     = 4'bxxxx;
    bus.id_mem_to_reg = 1'bx;
    bus.id_rt         = 5'd12;
    tick;
    chk("inv_valid", bus.ex_valid, 1'b0);
    chk("inv_aluop", bus.ex_alu_op, 4'h0);
    chk("inv_rw", bus.ex_reg_write, 1'b0);
    chk("inv_mr", bus.ex_mem_read, 2'b00);
    chk("inv_rdst", bus.ex_reg_dst, 1'b0);
    chk("inv_dest", bus.ex_dest, 5'd12);
    chk("inv_cnt", bubble_count, 4'd4);

    // Saturation: 15 more flush bubbles (19 total) stick at 0xF
    flush = 1'b1;
    for (int i = 0; i < 10; i++) tick;
    chk("sat_14", bubble_count, 4'd14);
    tick;
    chk("sat_15", bubble_count, 4'hF);
    for (int i = 0; i < 4; i++) tick;
    chk("sat_hold_f", bubble_count, 4'hF);
    flush = 1'b0;

    // Reset in the middle of a hold
    hold = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    chk("rst_hold_cnt", bubble_count, 4'd0);
    chk("rst_hold_valid", bus.ex_valid, 1'b0);
    chk("rst_hold_pcw", pc_write, 1'b0);
    #2 rst_n = 1'b1;
    hold = 1'b0;
    tick;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage, directly downstream of the main decoder (opcode → RegDst/Jump/Branch/MemRead/MemtoReg/ALUOp/MemWrite/ALUSrc/RegWrite).
- Registers the decoder's control word together with register-file operands, sign-extended immediate and register specifiers for the EX stage.
- Detects load-use hazards and injects bubbles, with stall, flush and hold control.
- Keeps a saturating bubble counter for performance inspection.

## Interface
Parameters:
- DATA_W, 32, operand/PC width
- CNT_W, 16, bubble counter width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- id_valid  in  1  ID holds a real instruction
- id_reg_dst, id_jump, id_branch, id_mem_to_reg, id_alu_src, id_reg_write  in  1 each  decoder controls
- id_mem_read, id_mem_write  in  2 each  00 none, 01 word, 10 byte, 11 half
- id_alu_op  in  4  decoder ALU op
- id_pc_plus4, id_rd1, id_rd2, id_imm  in  DATA_W each  PC+4, rs data, rt data, sign-extended immediate
- id_rs, id_rt, id_rd  in  5 each  register specifiers
- id_uses_rt  in  1  instruction reads rt as a source (R-type, store, branch)
- flush  in  1  branch/jump redirect from later stage; kill instruction entering EX
- hold  in  1  downstream stall; freeze this stage
- ex_* outputs  out  same widths as the id_* counterparts above: registered copies (ex_valid, ex_reg_dst … ex_alu_op, ex_pc_plus4, ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt, ex_rd)
- ex_dest  out  5  registered destination: ex_rd if reg_dst else ex_rt
- load_use_stall  out  1  combinational hazard flag
- pc_write, if_id_write  out  1 each  = ~(load_use_stall | hold)
- bubble_count  out  CNT_W  saturating count of injected bubbles

## Operation
- Hazard detection, combinational:
  - load_use_stall = ex_valid & (ex_mem_read != 00) & ex_reg_write & (ex_dest != 0) & id_valid & ((ex_dest == id_rs) | (id_uses_rt & ex_dest == id_rt)).
- Per-edge update priority:
  1. rst_n low: all registers cleared.
  2. flush: bubble loaded; takes precedence over hold.
  3. hold: all registers keep their value; no bubble counted.
  4. load_use_stall: bubble loaded.
  5. Otherwise: load all id_* fields. id_valid low also loads a bubble, but is not counted.
- Bubble:
  - ex_valid = 0; every control output 0 (mem_read/mem_write 00, alu_op 0000).
  - Data and specifier fields loaded normally (don't-care).
  - X on control inputs never propagates when a bubble is loaded.
- Valid load:
  - Controls and data pass through unchanged.
  - ex_dest computed from id_reg_dst/id_rd/id_rt at load time.
- Bubble counter:
  - Increments by 1 on each edge that loads a bubble due to flush or load_use_stall.
  - Saturates at all-ones; never wraps.

## Timing
- Latency: 1 cycle ID→EX.
- Reset values: every ex_* output and bubble_count are 0.
- pc_write = 1 and if_id_write = 1 while in reset with hold low.
- Reset is asynchronous; outputs clear immediately on rst_n fall, even mid-stall or mid-hold.
- First load happens on the first rising edge after rst_n rises.
- Load-use: the stall lasts exactly one cycle.
  - Once the bubble is in EX, ex_valid = 0, so load_use_stall deasserts.
  - The held ID instruction then loads on the next edge.
- flush and load_use_stall together: one bubble, counter +1 (not +2).
- hold and load_use_stall together: frozen; pc_write/if_id_write = 0; stall re-evaluated after hold releases.
- No internal state other than the registers and the counter; no FSM beyond the priority above.

## Test plan
- Reset: drive inputs to nonzero, pulse rst_n low mid-cycle → all outputs 0 asynchronously, bubble_count = 0.
- Pass-through: addi (reg_dst 0, alu_op 0100, alu_src 1, reg_write 1, rt = 8, rd1 = 0x10, imm = 0x5), then R-type (rd = 9) → each appears on ex_* one edge later; ex_dest = 8, then 9.
- Load-use: lw with rt = 5 (reg_dst 0, mem_read 01) followed by an instruction with rs = 5 →
  - load_use_stall = 1 and pc_write = 0 for one cycle.
  - Next cycle: ex_valid = 0, all controls 0, bubble_count = 1.
  - Following edge: the dependent instruction loads.
- No false hazard: lw to $0; or an R-type reading rt = 5 with id_uses_rt = 0 → load_use_stall stays 0.
- Flush + hold: assert hold for 3 cycles → ex_* frozen. Then assert flush together with hold → bubble loaded, count +1.
- Saturation: force 2^CNT_W + 3 bubbles (CNT_W = 4 for the test) → bubble_count sticks at 0xF.
